// File: rtl/array_force_pkg.sv
// Shared types and helpers for the array force/release stage.
// Holds the operation enum and the index range check used by every index bus.
package array_force_pkg;

  typedef enum logic [1:0] {
    OP_WR,
    OP_FRC,
    OP_REL,
    OP_RD
  } op_e;

  localparam int unsigned NUM_OPS = 4;

  function automatic logic idx_in_range(input logic [31:0] idx,
                                        input int unsigned lo,
                                        input int unsigned hi);
    return (idx >= lo) && (idx <= hi);
  endfunction

endpackage

// File: rtl/array_force_idx_chk.sv
// Combinational legality check for one index bus (range LO..HI).
// Optional macro ARRAY_FORCE_XIDX_CHK_EN also rejects indices carrying X/Z bits.
module array_force_idx_chk
  import array_force_pkg::*;
#(
  parameter int IDXW = 4,
  parameter int LO   = 1,
  parameter int HI   = 2
) (
  input  logic [IDXW-1:0] idx,
  output logic            legal
);

  always_comb begin
`ifdef ARRAY_FORCE_XIDX_CHK_EN
    legal = !$isunknown(idx) && idx_in_range(32'(idx), LO, HI);
`else
    legal = idx_in_range(32'(idx), LO, HI);
`endif
  end

endmodule

// File: rtl/array_force_stage.sv
// Word array with per-entry force/release override, one tracking slot and a registered read port.
// Illegal-index ops are dropped and counted; ARRAY_FORCE_XIDX_CHK_EN adds X/Z index rejection.
module array_force_stage
  import array_force_pkg::*;
#(
  parameter int WIDTH = 2,
  parameter int LO    = 1,
  parameter int HI    = 2,
  parameter int IDXW  = 4,
  parameter int CNTW  = 8
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               wr_en,
  input  logic [IDXW-1:0]    wr_idx,
  input  logic [WIDTH-1:0]   wr_data,
  input  logic               frc_en,
  input  logic [IDXW-1:0]    frc_idx,
  input  logic               frc_track,
  input  logic [WIDTH-1:0]   frc_val,
  input  logic               rel_en,
  input  logic               rd_en,
  input  logic [IDXW-1:0]    rd_idx,
  output logic [WIDTH-1:0]   rd_data,
  output logic               rd_vld,
  output logic               drop,
  output logic [CNTW-1:0]    drop_cnt,
  output logic [HI-LO:0]     forced
);

  localparam int NENT = HI - LO + 1;

  logic wr_ok, frc_ok, rd_ok;

  array_force_idx_chk #(.IDXW(IDXW), .LO(LO), .HI(HI)) u_wr_chk  (.idx(wr_idx),  .legal(wr_ok));
  array_force_idx_chk #(.IDXW(IDXW), .LO(LO), .HI(HI)) u_frc_chk (.idx(frc_idx), .legal(frc_ok));
  array_force_idx_chk #(.IDXW(IDXW), .LO(LO), .HI(HI)) u_rd_chk  (.idx(rd_idx),  .legal(rd_ok));

  logic [NENT-1:0][WIDTH-1:0] under_q, under_d;
  logic [NENT-1:0][WIDTH-1:0] fval_q, fval_d;
  logic [NENT-1:0]            forced_q, forced_d;
  logic                       trk_vld_q, trk_vld_d;
  logic [IDXW-1:0]            trk_idx_q, trk_idx_d;
  logic [WIDTH-1:0]           rd_data_q, rd_data_d;
  logic                       rd_vld_q, rd_vld_d;
  logic                       drop_q, drop_d;
  logic [CNTW-1:0]            drop_cnt_q, drop_cnt_d;

  logic [NENT-1:0] wr_hit, frc_hit, rd_hit, trk_hit;
  logic [NUM_OPS-1:0] drop_vec;
  logic [2:0]         drop_n;
  logic [CNTW:0]      cnt_sum;

  // Hit vectors only assert for legal indices, so dropped ops never touch state.
  always_comb begin
    for (int i = 0; i < NENT; i++) begin
      wr_hit[i]  = wr_en && wr_ok && (wr_idx == IDXW'(i + LO));
      frc_hit[i] = frc_ok && (frc_idx == IDXW'(i + LO));
      rd_hit[i]  = rd_en && rd_ok && (rd_idx == IDXW'(i + LO));
      trk_hit[i] = trk_vld_q && (trk_idx_q == IDXW'(i + LO));
    end
  end

  always_comb begin
    under_d   = under_q;
    fval_d    = fval_q;
    forced_d  = forced_q;
    trk_vld_d = trk_vld_q;
    trk_idx_d = trk_idx_q;
    for (int i = 0; i < NENT; i++) begin
      if (wr_hit[i]) under_d[i] = wr_data;
      if (trk_hit[i]) fval_d[i] = frc_val;
      if (frc_en && frc_hit[i]) begin
        forced_d[i] = 1'b1;
        fval_d[i]   = frc_val;
      end else if (rel_en && frc_hit[i]) begin
        forced_d[i] = 1'b0;
      end
    end
    // A force or release of the tracked entry ends its tracking.
    if (frc_en && frc_ok) begin
      if (frc_track) begin
        trk_vld_d = 1'b1;
        trk_idx_d = frc_idx;
      end else if (trk_vld_q && (trk_idx_q == frc_idx)) begin
        trk_vld_d = 1'b0;
      end
    end else if (rel_en && frc_ok && trk_vld_q && (trk_idx_q == frc_idx)) begin
      trk_vld_d = 1'b0;
    end
  end

  always_comb begin
    rd_vld_d  = rd_en;
    rd_data_d = rd_data_q;
    if (rd_en) begin
      rd_data_d = '0;
      for (int i = 0; i < NENT; i++) begin
        if (rd_hit[i]) rd_data_d = forced_q[i] ? fval_q[i] : under_q[i];
      end
    end
  end

  // Force and release share one index bus, so they can only cost one drop per cycle.
  always_comb begin
    drop_vec         = '0;
    drop_vec[OP_WR]  = wr_en && !wr_ok;
    drop_vec[OP_FRC] = frc_en && !frc_ok;
    drop_vec[OP_REL] = rel_en && !frc_en && !frc_ok;
    drop_vec[OP_RD]  = rd_en && !rd_ok;
    drop_n = '0;
    for (int k = 0; k < NUM_OPS; k++) begin
      drop_n = drop_n + {2'b00, drop_vec[k]};
    end
    cnt_sum    = {1'b0, drop_cnt_q} + (CNTW + 1)'(drop_n);
    drop_cnt_d = cnt_sum[CNTW] ? '1 : cnt_sum[CNTW-1:0];
    drop_d     = |drop_vec;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      under_q    <= '0;
      fval_q     <= '0;
      forced_q   <= '0;
      trk_vld_q  <= 1'b0;
      trk_idx_q  <= '0;
      rd_data_q  <= '0;
      rd_vld_q   <= 1'b0;
      drop_q     <= 1'b0;
      drop_cnt_q <= '0;
    end else begin
      under_q    <= under_d;
      fval_q     <= fval_d;
      forced_q   <= forced_d;
      trk_vld_q  <= trk_vld_d;
      trk_idx_q  <= trk_idx_d;
      rd_data_q  <= rd_data_d;
      rd_vld_q   <= rd_vld_d;
      drop_q     <= drop_d;
      drop_cnt_q <= drop_cnt_d;
    end
  end

  assign rd_data  = rd_data_q;
  assign rd_vld   = rd_vld_q;
  assign drop     = drop_q;
  assign drop_cnt = drop_cnt_q;
  assign forced   = forced_q;

endmodule

// File: tb/tb_array_force_stage.sv
// Directed bench for array_force_stage with hand-computed expectations.
// The X-index vector is included only when ARRAY_FORCE_XIDX_CHK_EN is defined.
module tb_array_force_stage;

  localparam int WIDTH = 2;
  localparam int LO    = 1;
  localparam int HI    = 2;
  localparam int IDXW  = 4;
  localparam int CNTW  = 8;

  logic             clk = 1'b0;
  logic             reset;
  logic             wr_en;
  logic [IDXW-1:0]  wr_idx;
  logic [WIDTH-1:0] wr_data;
  logic             frc_en;
  logic [IDXW-1:0]  frc_idx;
  logic             frc_track;
  logic [WIDTH-1:0] frc_val;
  logic             rel_en;
  logic             rd_en;
  logic [IDXW-1:0]  rd_idx;
  logic [WIDTH-1:0] rd_data;
  logic             rd_vld;
  logic             drop;
  logic [CNTW-1:0]  drop_cnt;
  logic [HI-LO:0]   forced;

  int total = 0;
  int bad   = 0;
  int exp_cnt = 0;

  always #5 clk = ~clk;

  array_force_stage #(
    .WIDTH(WIDTH), .LO(LO), .HI(HI), .IDXW(IDXW), .CNTW(CNTW)
  ) dut (
    .clk(clk), .reset(reset),
    .wr_en(wr_en), .wr_idx(wr_idx), .wr_data(wr_data),
    .frc_en(frc_en), .frc_idx(frc_idx), .frc_track(frc_track), .frc_val(frc_val),
    .rel_en(rel_en),
    .rd_en(rd_en), .rd_idx(rd_idx),
    .rd_data(rd_data), .rd_vld(rd_vld),
    .drop(drop), .drop_cnt(drop_cnt), .forced(forced)
  );

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // One clock of stimulus; outputs are sampled 1ns after the edge.
  task automatic applyStimulus(input logic wr, input logic [IDXW-1:0] widx, input logic [WIDTH-1:0] wdata,
                               input logic frc, input logic [IDXW-1:0] fidx, input logic trk,
                               input logic [WIDTH-1:0] fval, input logic rel,
                               input logic rd, input logic [IDXW-1:0] ridx);
    wr_en = wr; wr_idx = widx; wr_data = wdata;
    frc_en = frc; frc_idx = fidx; frc_track = trk; frc_val = fval;
    rel_en = rel; rd_en = rd; rd_idx = ridx;
    @(posedge clk);
    #1;
    wr_en = 1'b0; frc_en = 1'b0; rel_en = 1'b0; rd_en = 1'b0;
  endtask

  task automatic doWrite(input logic [IDXW-1:0] idx, input logic [WIDTH-1:0] d);
    applyStimulus(1'b1, idx, d, 1'b0, '0, 1'b0, frc_val, 1'b0, 1'b0, '0);
  endtask

  task automatic doForce(input logic [IDXW-1:0] idx, input logic [WIDTH-1:0] v, input logic trk);
    applyStimulus(1'b0, '0, '0, 1'b1, idx, trk, v, 1'b0, 1'b0, '0);
  endtask

  task automatic doRelease(input logic [IDXW-1:0] idx);
    applyStimulus(1'b0, '0, '0, 1'b0, idx, 1'b0, frc_val, 1'b1, 1'b0, '0);
  endtask

  task automatic doIdle(input logic [WIDTH-1:0] v);
    applyStimulus(1'b0, '0, '0, 1'b0, '0, 1'b0, v, 1'b0, 1'b0, '0);
  endtask

  task automatic doRead(input logic [IDXW-1:0] idx, input logic [WIDTH-1:0] exp, input string tag);
    applyStimulus(1'b0, '0, '0, 1'b0, '0, 1'b0, frc_val, 1'b0, 1'b1, idx);
    checkOutput({tag, "_data"}, 32'(rd_data), 32'(exp));
    checkOutput({tag, "_vld"}, 32'(rd_vld), 32'd1);
  endtask

  initial begin
    logic [IDXW-1:0] x_idx;
    x_idx = 'x;
    reset = 1'b1;
    wr_en = 1'b0; wr_idx = '0; wr_data = '0;
    frc_en = 1'b0; frc_idx = '0; frc_track = 1'b0; frc_val = '0;
    rel_en = 1'b0; rd_en = 1'b0; rd_idx = '0;
    repeat (2) @(posedge clk);
    #1;
    checkOutput("rst_rd_data", 32'(rd_data), 32'd0);
    checkOutput("rst_rd_vld", 32'(rd_vld), 32'd0);
    checkOutput("rst_drop", 32'(drop), 32'd0);
    checkOutput("rst_drop_cnt", 32'(drop_cnt), 32'd0);
    checkOutput("rst_forced", 32'(forced), 32'd0);
    reset = 1'b0;

    doWrite(4'd1, 2'd0);
    doWrite(4'd2, 2'd0);
    checkOutput("wr_no_drop", 32'(drop_cnt), 32'd0);

    // Force below LO is dropped.
    doForce(4'd0, 2'd1, 1'b0);
    exp_cnt = 1;
    checkOutput("frc0_drop", 32'(drop), 32'd1);
    checkOutput("frc0_cnt", 32'(drop_cnt), 32'(exp_cnt));
    checkOutput("frc0_forced", 32'(forced), 32'd0);
    doRead(4'd1, 2'd0, "frc0_rd1");
    checkOutput("drop_pulse_end", 32'(drop), 32'd0);
    doRead(4'd2, 2'd0, "frc0_rd2");

    // Captured force and release.
    doForce(4'd1, 2'd1, 1'b0);
    checkOutput("frc1_forced", 32'(forced), 32'b01);
    doRead(4'd1, 2'd1, "frc1_rd1");
    doRead(4'd2, 2'd0, "frc1_rd2");
    doRelease(4'd1);
    checkOutput("rel1_forced", 32'(forced), 32'b00);
    doRead(4'd1, 2'd0, "rel1_rd1");

    // Tracking force follows frc_val until released.
    doForce(4'd2, 2'd1, 1'b1);
    checkOutput("trk2_forced", 32'(forced), 32'b10);
    doRead(4'd2, 2'd1, "trk2_rd_a");
    doIdle(2'd2);
    doRead(4'd2, 2'd2, "trk2_rd_b");
    doRelease(4'd2);
    checkOutput("rel2_forced", 32'(forced), 32'b00);
    doIdle(2'd3);
    doRead(4'd2, 2'd0, "rel2_rd2");

    // Force above HI is dropped.
    doForce(4'd3, 2'd1, 1'b0);
    exp_cnt = exp_cnt + 1;
    checkOutput("frc3_cnt", 32'(drop_cnt), 32'(exp_cnt));
    checkOutput("frc3_forced", 32'(forced), 32'b00);
`ifdef ARRAY_FORCE_XIDX_CHK_EN
    doForce(x_idx, 2'd1, 1'b0);
    exp_cnt = exp_cnt + 1;
    checkOutput("frcx_cnt", 32'(drop_cnt), 32'(exp_cnt));
    checkOutput("frcx_forced", 32'(forced), 32'b00);
    doRead(4'd1, 2'd0, "frcx_rd1");
    doRead(4'd2, 2'd0, "frcx_rd2");
`endif

    // Three illegal ops in one cycle; force+release count once.
    applyStimulus(1'b1, 4'd0, 2'd1, 1'b1, 4'd3, 1'b0, 2'd0, 1'b1, 1'b1, 4'd5);
    exp_cnt = exp_cnt + 3;
    checkOutput("multi_cnt", 32'(drop_cnt), 32'(exp_cnt));
    checkOutput("multi_rd_vld", 32'(rd_vld), 32'd1);
    checkOutput("multi_rd_data", 32'(rd_data), 32'd0);

    // Write under force stays hidden until release.
    doForce(4'd1, 2'd3, 1'b0);
    doWrite(4'd1, 2'd2);
    doRead(4'd1, 2'd3, "frcwr_rd1");
    doRelease(4'd1);
    doRead(4'd1, 2'd2, "relwr_rd1");

    // Same-cycle write and read returns the old word.
    applyStimulus(1'b1, 4'd1, 2'd1, 1'b0, '0, 1'b0, frc_val, 1'b0, 1'b1, 4'd1);
    checkOutput("nowt_rd_data", 32'(rd_data), 32'd2);
    doRead(4'd1, 2'd1, "nowt_rd_after");

    // Force wins over release in the same cycle.
    applyStimulus(1'b0, '0, '0, 1'b1, 4'd2, 1'b0, 2'd1, 1'b1, 1'b0, '0);
    checkOutput("frcrel_forced", 32'(forced), 32'b10);
    doRead(4'd2, 2'd1, "frcrel_rd2");

    // New tracked entry leaves the old one forced at its last value.
    doForce(4'd1, 2'd2, 1'b1);
    doForce(4'd2, 2'd2, 1'b1);
    doIdle(2'd3);
    checkOutput("trkrep_forced", 32'(forced), 32'b11);
    doRead(4'd1, 2'd2, "trkrep_rd1");
    doRead(4'd2, 2'd3, "trkrep_rd2");

    // Reset in the middle of active forces.
    reset = 1'b1;
    doIdle(2'd0);
    reset = 1'b0;
    checkOutput("mrst_forced", 32'(forced), 32'd0);
    checkOutput("mrst_rd_data", 32'(rd_data), 32'd0);
    checkOutput("mrst_drop_cnt", 32'(drop_cnt), 32'd0);
    checkOutput("mrst_rd_vld", 32'(rd_vld), 32'd0);
    doRead(4'd1, 2'd0, "mrst_rd1");
    doRead(4'd2, 2'd0, "mrst_rd2");

    // Saturation of the drop counter.
    for (int n = 0; n < 50; n++)
      applyStimulus(1'b1, 4'd0, 2'd0, 1'b1, 4'd3, 1'b0, 2'd0, 1'b0, 1'b1, 4'd9);
    checkOutput("sat_mid_cnt", 32'(drop_cnt), 32'd150);
    for (int n = 0; n < 50; n++)
      applyStimulus(1'b1, 4'd0, 2'd0, 1'b1, 4'd3, 1'b0, 2'd0, 1'b0, 1'b1, 4'd9);
    checkOutput("sat_cnt", 32'(drop_cnt), 32'd255);
    applyStimulus(1'b0, '0, '0, 1'b0, '0, 1'b0, 2'd0, 1'b0, 1'b1, 4'd15);
    checkOutput("sat_hold_cnt", 32'(drop_cnt), 32'd255);
    checkOutput("sat_hold_drop", 32'(drop), 32'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/array_force_stage.md
Name: array_force_stage

Overview:
- Word-array storage stage with a procedural-style override ("force/release") port per entry, plus a registered read port.
- Sits directly upstream of the array read/check logic. Feeds it array words that honour force, release and normal-write semantics.
- Operations with an out-of-range or unknown (X/Z) index are dropped without side effects and reported.
- Entries follow net semantics: release reverts an entry to its underlying driven value.

Parameters:
- WIDTH, 2, data word width in bits.
- LO, 1, lowest legal array index (inclusive).
- HI, 2, highest legal array index (inclusive); HI >= LO required.
- IDXW, 4, index bus width; must cover HI+1 so that out-of-range values are expressible.
- CNTW, 8, width of the dropped-operation counter.

Ports:
- clk  in  1  single clock; all state updates on posedge.
- reset  in  1  synchronous, active-high reset.
- wr_en  in  1  write underlying driver value.
- wr_idx  in  IDXW  write index.
- wr_data  in  WIDTH  write data.
- frc_en  in  1  start forcing entry frc_idx.
- frc_idx  in  IDXW  force/release index.
- frc_track  in  1  1: forced value follows frc_val every cycle; 0: value captured once.
- frc_val  in  WIDTH  force value source.
- rel_en  in  1  release entry frc_idx.
- rd_en  in  1  read request.
- rd_idx  in  IDXW  read index.
- rd_data  out  WIDTH  read result, registered.
- rd_vld  out  1  rd_data valid, one cycle after rd_en.
- drop  out  1  one-cycle pulse: at least one operation was dropped this cycle.
- drop_cnt  out  CNTW  saturating count of dropped operations.
- forced  out  HI-LO+1  per-entry force-active flags; bit 0 = entry LO.

Behaviour:
- Reset: all underlying words 0, all forced flags 0, tracking slot empty, rd_data 0, rd_vld 0, drop 0, drop_cnt 0.
- Legal index: LO <= idx <= HI and no X/Z bits. Any other op is dropped (no state change) and counted.
- Read: 1-cycle latency. rd_data returns the forced value if the entry is forced, else the underlying word. Reads see state from before the same-cycle edge, i.e. no write-through.
- Dropped read: rd_vld=1 and rd_data=0 the next cycle.
- Write to a forced entry: updates the underlying word only. The visible value is unchanged until release.
- Release: clears the forced flag. The next read returns the underlying word, including writes made during the force.
- Release of an unforced legal entry: no-op, not counted as a drop.
- Tracking: only one entry may be tracked at a time.
  - A frc_track=1 force replaces the previous tracked entry. That entry stays forced, holding the frc_val sampled in its last tracked cycle.
  - The tracked entry's forced value is reloaded from frc_val every cycle until it is released or re-forced with frc_track=0.
- frc_en and rel_en in the same cycle: frc_en wins (entry ends forced). A force on an already-forced entry overwrites its value and tracking mode.
- Each cycle, every dropped op (write, force, release, read) adds 1 to drop_cnt. Up to 3 per cycle; force and release count as one op. drop_cnt saturates at all-ones.
- Reset asserted mid-force: all forces are cleared and underlying words return to 0.

Optional Feature:
- Macro: ARRAY_FORCE_XIDX_CHK_EN.
- Defined: any X/Z bit in an index classifies the op as illegal (drop + count).
- Undefined: no X/Z check. An X/Z index yields an unknown in-range match, so the bench must not drive X indices. Out-of-range checking is unaffected.

Decomposition:
- Package array_force_pkg: op-type enum (OP_WR, OP_FRC, OP_REL, OP_RD) and an index-legality function parameterised by LO/HI.
- One sub-module, array_force_idx_chk: combinational legality check used for each of the 3 index buses. The X/Z test lives here under the macro.

Test Plan:
- LO=1,HI=2. Write entries 1 and 2 = 0. Force idx 0 = 1 -> drop pulse, drop_cnt=1; reads return 2'd0, 2'd0.
- Force idx 1 = 1 (captured). Read 1 -> 1, read 2 -> 0. Release idx 1, read 1 -> 0.
- Force idx 2 with track=1 and frc_val=1: read 2 -> 1. Change frc_val to 2: next read 2 -> 2. Release: read 2 -> 0.
- Force idx 3 -> dropped, drop_cnt increments, forced=2'b00. With ARRAY_FORCE_XIDX_CHK_EN, force idx 'bx -> dropped, entries remain 0.
- Force idx 1 = 3. Write idx 1 = 2 -> read 1 returns 3. Release -> read 1 returns 2. Same-cycle frc_en+rel_en on idx 2 -> forced[1]=1.
- Reset while idx 1 is forced -> forced=0, rd_data=0, drop_cnt=0. Drive 300 illegal ops with CNTW=8 -> drop_cnt saturates at 255.
